// File: rtl/vga_sync_monitor.sv
// Passive VGA timing monitor: resyncs to hsync/vsync, flags timing violations and rebuilds
// visible pixel coordinates. Define VGA_MONITOR_CRC_EN to add a per-frame CRC-16 of the pixels.
module vga_sync_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic [1:0]  i_vga_r,
  input  logic [1:0]  i_vga_g,
  input  logic [1:0]  i_vga_b,
  output logic        o_locked,
  output logic        o_pixel_valid,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic [5:0]  o_rgb,
  output logic        o_frame_done,
  output logic        o_error,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_frame_crc
);

  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);
  localparam logic [9:0] H_LAST      = 10'(H_FP + H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_VIS0      = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS1      = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_VIS0      = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS1      = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic       hs_q, hs_d, vs_q, vs_d;
  logic [5:0] rgb_q;
  logic [9:0] hcnt_r, vcnt_r, hcnt, vcnt;
  logic       h_seen, v_pend, v_synced;
  logic       h_rise, h_fall, v_rise, v_fall, resync;
  logic       h_ovf, v_ovf, viol, vis, pix_v, frame_evt;
  state_t     state_q, state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0; hs_d <= 1'b0; vs_q <= 1'b0; vs_d <= 1'b0; rgb_q <= '0;
    end else begin
      hs_q  <= i_vga_hsync;
      hs_d  <= hs_q;
      vs_q  <= i_vga_vsync;
      vs_d  <= vs_q;
      rgb_q <= {i_vga_r, i_vga_g, i_vga_b};
    end
  end

  assign h_rise = hs_q & ~hs_d;
  assign h_fall = ~hs_q & hs_d;
  assign v_rise = vs_q & ~vs_d;
  assign v_fall = ~vs_q & vs_d;
  // Line 0 is the first hsync rise at or after the vsync rise (including a coincident one).
  assign resync = h_rise & (v_pend | v_rise);

  always_comb begin
    hcnt  = hcnt_r;
    vcnt  = vcnt_r;
    h_ovf = 1'b0;
    v_ovf = 1'b0;
    if (h_rise) hcnt = '0;
    else if (hcnt_r != CNT_MAX) begin
      hcnt  = hcnt_r + 10'd1;
      h_ovf = (hcnt_r == CNT_MAX - 10'd1);
    end
    if (resync) vcnt = '0;
    else if (h_rise && vcnt_r != CNT_MAX) begin
      vcnt  = vcnt_r + 10'd1;
      v_ovf = (vcnt_r == CNT_MAX - 10'd1);
    end
  end

  // Checks are armed only once the counter they read has been anchored by a real edge,
  // so a reset mid-frame never produces a spurious violation.
  always_comb begin
    viol = h_ovf | v_ovf;
    if (h_fall && h_seen && hcnt != H_SYNC_W)      viol = 1'b1;
    if (h_rise && h_seen && hcnt_r != H_LAST)      viol = 1'b1;
    if (v_fall && v_synced && vcnt_r != V_SYNC_LAST) viol = 1'b1;
    if (v_rise && v_synced && vcnt_r != V_LAST)    viol = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_r <= '0; vcnt_r <= '0;
      h_seen <= 1'b0; v_pend <= 1'b0; v_synced <= 1'b0;
    end else begin
      hcnt_r <= hcnt;
      vcnt_r <= vcnt;
      if (h_rise) h_seen <= 1'b1;
      if (resync) begin
        v_pend   <= 1'b0;
        v_synced <= 1'b1;
      end else if (v_rise) v_pend <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      SEARCH:  if (!viol && v_rise) state_n = MEASURE;
      MEASURE: if (viol) state_n = SEARCH; else if (v_rise) state_n = LOCKED;
      LOCKED:  if (viol) state_n = SEARCH;
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_n;
  end

  assign o_locked  = (state_q == LOCKED);
  assign frame_evt = v_rise & (state_q != SEARCH);
  assign vis       = (hcnt >= H_VIS0) && (hcnt < H_VIS1) && (vcnt >= V_VIS0) && (vcnt < V_VIS1);
  assign pix_v     = vis & (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pixel_valid <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_rgb         <= '0;
      o_frame_done  <= 1'b0;
      o_error       <= 1'b0;
      o_err_count   <= '0;
    end else begin
      o_pixel_valid <= pix_v;
      o_frame_done  <= frame_evt;
      o_error       <= viol;
      if (pix_v) begin
        o_x   <= hcnt - H_VIS0;
        o_y   <= vcnt - V_VIS0;
        o_rgb <= rgb_q;
      end
      if (viol && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

`ifdef VGA_MONITOR_CRC_EN
  // CRC-16-CCITT, MSB first over the 6 colour bits of each valid pixel.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  logic [15:0] crc_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc     <= 16'hFFFF;
      o_frame_crc <= '0;
    end else if (frame_evt) begin
      o_frame_crc <= crc_acc;
      crc_acc     <= 16'hFFFF;
    end else if (pix_v) begin
      crc_acc <= crc16_step(crc_acc, rgb_q);
    end
  end
`else
  assign o_frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a shrunken 15x11 raster (8x6 visible) so that
// many frames fit in a short run; covers lock, coordinates, violations, saturation and reset.
module tb_vga_sync_monitor;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int HV0 = HS + HB;            // 5
  localparam int VV0 = VS + VB;            // 4

  logic clk = 1'b0;
  logic rst;
  logic hs, vs;
  logic [1:0] r, g, b;
  logic        o_locked, o_pixel_valid, o_frame_done, o_error;
  logic [9:0]  o_x, o_y;
  logic [5:0]  o_rgb;
  logic [7:0]  o_err_count;
  logic [15:0] o_frame_crc;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst),
    .i_vga_hsync(hs), .i_vga_vsync(vs),
    .i_vga_r(r), .i_vga_g(g), .i_vga_b(b),
    .o_locked(o_locked), .o_pixel_valid(o_pixel_valid),
    .o_x(o_x), .o_y(o_y), .o_rgb(o_rgb),
    .o_frame_done(o_frame_done), .o_error(o_error),
    .o_err_count(o_err_count), .o_frame_crc(o_frame_crc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int vrise_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output observer: pulse counters and per-frame pixel statistics, snapshotted at frame_done.
  int   err_pulses = 0, fd_pulses = 0, rgb_bad = 0, lock_rise_cyc = -1;
  logic lk_prev = 1'b0;
  int   cur_pix = 0, cur_fx = -1, cur_fy = -1, cur_lx = -1, cur_ly = -1;
  int   snap_pix = 0, snap_fx = -1, snap_fy = -1, snap_lx = -1, snap_ly = -1;

  always @(negedge clk) begin
    if (o_error) err_pulses++;
    if (o_locked && !lk_prev) lock_rise_cyc = cyc;
    lk_prev = o_locked;
    if (o_frame_done) begin
      fd_pulses++;
      snap_pix = cur_pix; snap_fx = cur_fx; snap_fy = cur_fy; snap_lx = cur_lx; snap_ly = cur_ly;
      cur_pix = 0; cur_fx = -1; cur_fy = -1; cur_lx = -1; cur_ly = -1;
    end
    if (o_pixel_valid) begin
      if (cur_pix == 0) begin cur_fx = int'(o_x); cur_fy = int'(o_y); end
      cur_lx = int'(o_x); cur_ly = int'(o_y);
      cur_pix++;
      if (o_rgb !== {o_x[1:0], o_x[1:0], o_x[1:0]}) rgb_bad++;
    end
  end

  // One raster line; colour = x[1:0] replicated, optionally with one bit flipped at flip_x.
  task automatic run_line(input int v, input int period, input int hw, input int flip_x);
    int x;
    logic [5:0] px;
    for (int gh = 0; gh < period; gh++) begin
      @(posedge clk); #1;
      hs = (gh < hw);
      vs = (v < VS);
      if (v == 0 && gh == 0) vrise_cyc = cyc;
      px = '0;
      if (gh >= HV0 && gh < HV0 + HA && v >= VV0 && v < VV0 + VA) begin
        x  = gh - HV0;
        px = {x[1:0], x[1:0], x[1:0]};
        if (x == flip_x) px = px ^ 6'd1;
      end
      {r, g, b} = px;
    end
  endtask

  task automatic run_rows(input int v0, input int v1, input int bad_v, input int bper,
                          input int bhw, input int flip_v, input int flip_x);
    for (int v = v0; v <= v1; v++)
      run_line(v, (v == bad_v) ? bper : HT, (v == bad_v) ? bhw : HS, (v == flip_v) ? flip_x : -1);
  endtask

  task automatic clean_frame();
    run_rows(0, VT - 1, -1, HT, HS, -1, -1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_locked, o_pixel_valid, o_frame_done, o_error, o_x, o_y, o_rgb, o_err_count, o_frame_crc} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {o_locked, o_pixel_valid, o_frame_done, o_error, o_x, o_y, o_rgb, o_err_count, o_frame_crc});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (o_locked !== 1'b0 || o_err_count !== 8'd0) begin
      failures++;
      $display("FAIL idle_after_reset locked=%0b errs=%0d exp=0/0", o_locked, o_err_count);
    end
  endtask

  task automatic test_lock();
    int e0;
    e0 = err_pulses;
    clean_frame();
    checks++;
    if (o_locked !== 1'b0) begin failures++; $display("FAIL lock_after_one_vsync got=%0b exp=0", o_locked); end
    clean_frame();
    checks++;
    if (o_locked !== 1'b1) begin failures++; $display("FAIL lock_after_two_vsync got=%0b exp=1", o_locked); end
    checks++;
    if (lock_rise_cyc - vrise_cyc != 2) begin
      failures++; $display("FAIL lock_latency got=%0d exp=2", lock_rise_cyc - vrise_cyc);
    end
    checks++;
    if (err_pulses != e0) begin failures++; $display("FAIL lock_no_errors got=%0d exp=0", err_pulses - e0); end
  endtask

  task automatic test_ideal_frames();
    int e0, f0;
    e0 = err_pulses; f0 = fd_pulses;
    clean_frame();
    clean_frame();
    checks++;
    if (snap_pix != HA * VA) begin failures++; $display("FAIL pixel_count got=%0d exp=%0d", snap_pix, HA * VA); end
    checks++;
    if (snap_fx != 0 || snap_fy != 0) begin
      failures++; $display("FAIL first_pixel got=(%0d,%0d) exp=(0,0)", snap_fx, snap_fy);
    end
    checks++;
    if (snap_lx != HA - 1 || snap_ly != VA - 1) begin
      failures++; $display("FAIL last_pixel got=(%0d,%0d) exp=(%0d,%0d)", snap_lx, snap_ly, HA - 1, VA - 1);
    end
    checks++;
    if (rgb_bad != 0) begin failures++; $display("FAIL pixel_colour got=%0d bad exp=0", rgb_bad); end
    checks++;
    if (err_pulses != e0 || o_err_count !== 8'd0) begin
      failures++; $display("FAIL ideal_no_error pulses=%0d count=%0d exp=0/0", err_pulses - e0, o_err_count);
    end
    checks++;
    if (fd_pulses != f0 + 2) begin failures++; $display("FAIL frame_done_count got=%0d exp=2", fd_pulses - f0); end
    checks++;
    if (o_locked !== 1'b1) begin failures++; $display("FAIL ideal_locked got=%0b exp=1", o_locked); end
  endtask

  // One faulty line, then two clean frames to re-acquire lock.
  task automatic test_bad_line(input string name, input int bhw, input int exp_pulses, input int exp_count);
    int e0;
    e0 = err_pulses;
    run_rows(0, VT - 1, 5, HT - 1, bhw, -1, -1);
    checks++;
    if (err_pulses != e0 + exp_pulses) begin
      failures++; $display("FAIL %s_pulses got=%0d exp=%0d", name, err_pulses - e0, exp_pulses);
    end
    checks++;
    if (o_err_count !== 8'(exp_count)) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", name, o_err_count, exp_count);
    end
    checks++;
    if (o_locked !== 1'b0) begin failures++; $display("FAIL %s_unlock got=%0b exp=0", name, o_locked); end
    clean_frame();
    checks++;
    if (o_locked !== 1'b0) begin failures++; $display("FAIL %s_measure got=%0b exp=0", name, o_locked); end
    clean_frame();
    checks++;
    if (o_locked !== 1'b1 || err_pulses != e0 + exp_pulses) begin
      failures++; $display("FAIL %s_relock locked=%0b pulses=%0d exp=1/%0d", name, o_locked, err_pulses - e0, exp_pulses);
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    run_rows(0, 6, -1, HT, HS, -1, -1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++;
    if ({o_locked, o_pixel_valid, o_frame_done, o_error, o_x, o_y, o_rgb, o_err_count, o_frame_crc} !== 54'd0) begin
      failures++;
      $display("FAIL midframe_reset_outputs got=%h exp=0",
               {o_locked, o_pixel_valid, o_frame_done, o_error, o_x, o_y, o_rgb, o_err_count, o_frame_crc});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e0 = err_pulses;
    run_rows(7, VT - 1, -1, HT, HS, -1, -1);
    clean_frame();
    checks++;
    if (o_locked !== 1'b0) begin failures++; $display("FAIL midframe_measure got=%0b exp=0", o_locked); end
    clean_frame();
    checks++;
    if (o_locked !== 1'b1) begin failures++; $display("FAIL midframe_relock got=%0b exp=1", o_locked); end
    checks++;
    if (lock_rise_cyc - vrise_cyc != 2) begin
      failures++; $display("FAIL midframe_lock_latency got=%0d exp=2", lock_rise_cyc - vrise_cyc);
    end
    checks++;
    if (err_pulses != e0 || o_err_count !== 8'd0) begin
      failures++; $display("FAIL midframe_no_error pulses=%0d count=%0d exp=0/0", err_pulses - e0, o_err_count);
    end
  endtask

  task automatic test_saturate();
    int e0;
    e0 = err_pulses;
    for (int i = 0; i < 300; i++) run_line(5, HT - 1, HS, -1);
    clean_frame();
    checks++;
    if (err_pulses != e0 + 300) begin failures++; $display("FAIL sat_pulses got=%0d exp=300", err_pulses - e0); end
    checks++;
    if (o_err_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", o_err_count); end
  endtask

`ifdef VGA_MONITOR_CRC_EN
  function automatic logic [15:0] crc_model(input int fy, input int fx);
    logic [15:0] c;
    logic [5:0] d;
    logic fb;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        d = {x[1:0], x[1:0], x[1:0]};
        if (y == fy && x == fx) d = d ^ 6'd1;
        for (int i = 5; i >= 0; i--) begin
          fb = c[15] ^ d[i];
          c  = {c[14:0], 1'b0};
          if (fb) c = c ^ 16'h1021;
        end
      end
    return c;
  endfunction
`endif

  task automatic test_crc();
`ifdef VGA_MONITOR_CRC_EN
    logic [15:0] crc_a, crc_b, crc_c, exp0, exp1;
    exp0 = crc_model(-1, -1);
    exp1 = crc_model(2, 3);
    clean_frame(); clean_frame(); clean_frame();
    crc_a = o_frame_crc;
    clean_frame();
    crc_b = o_frame_crc;
    run_rows(0, VT - 1, -1, HT, HS, VV0 + 2, 3);
    clean_frame();
    crc_c = o_frame_crc;
    checks++;
    if (crc_a !== exp0 || crc_b !== exp0) begin
      failures++; $display("FAIL crc_identical got=%h/%h exp=%h", crc_a, crc_b, exp0);
    end
    checks++;
    if (crc_c !== exp1 || crc_c === crc_a) begin
      failures++; $display("FAIL crc_changed_pixel got=%h exp=%h", crc_c, exp1);
    end
`else
    clean_frame(); clean_frame(); clean_frame();
    checks++;
    if (o_frame_crc !== 16'd0) begin failures++; $display("FAIL crc_disabled got=%h exp=0", o_frame_crc); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0;
    test_reset();
    test_lock();
    test_ideal_frames();
    test_bad_line("short_line", HS, 1, 1);
    test_bad_line("width_and_period", HS - 1, 2, 3);
    test_reset_midframe();
    test_saturate();
    test_crc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
